// File: rtl/rc_settle_monitor.sv
// rc_settle_monitor
// Step-response checker for the RC model output. A start request latches a
// target and a tolerance. The block then samples v_meas once per cycle. It
// reports the 1-based index of the first sample of the first run of
// HOLD_CYCLES consecutive in-band samples. If no such run completes by
// sample MAX_CYCLES, it reports a timeout instead.
//
// Optional feature: define RC_SETTLE_PEAK_EN to enable peak_err tracking.
// peak_err is the largest |v_meas - target| seen from the first in-band
// sample onward. When the macro is undefined, peak_err is tied to zero.
module rc_settle_monitor #(
    parameter int WIDTH       = 16,
    parameter int HOLD_CYCLES = 8,
    parameter int MAX_CYCLES  = 1000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] v_target,
    input  logic [WIDTH-1:0] tol,
    input  logic [WIDTH-1:0] v_meas,
    output logic             busy,
    output logic             done,
    output logic             settled,
    output logic             timed_out,
    output logic             in_band,
    output logic [CNT_W-1:0] settle_time,
    output logic [WIDTH:0]   peak_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRACK   = 2'd1,
        ST_SETTLED = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CYCLES);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] target_reg;
    logic [WIDTH-1:0] tol_reg;
    logic [CNT_W-1:0] cyc_reg;
    logic [CNT_W-1:0] run_reg;
    logic [CNT_W-1:0] cyc_next;
    logic [CNT_W-1:0] run_next;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   err;
    logic             in_now;
    logic             settle_hit;
    logic             timeout_hit;

    // The difference is sign-extended to WIDTH+1 bits, so it cannot wrap.
    // Its magnitude therefore always fits as an unsigned value.
    always_comb begin
        diff   = {v_meas[WIDTH-1], v_meas} - {target_reg[WIDTH-1], target_reg};
        err    = diff[WIDTH] ? (~diff + 1'b1) : diff;
        in_now = (err <= {1'b0, tol_reg});
    end

    // Next-state logic, and the sample and run counters for this TRACK cycle.
    always_comb begin
        state_next  = state_reg;
        cyc_next    = cyc_reg + 1'b1;
        run_next    = in_now ? (run_reg + 1'b1) : '0;
        settle_hit  = (run_next == HOLD_C);
        timeout_hit = (cyc_next == MAX_C) && !settle_hit;
        if (start) begin
            state_next = ST_TRACK;
        end else if (state_reg == ST_TRACK) begin
            if (settle_hit) begin
                state_next = ST_SETTLED;
            end else if (timeout_hit) begin
                state_next = ST_TIMEOUT;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Measurement datapath: latch on start, then update counters while in TRACK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target_reg  <= '0;
            tol_reg     <= '0;
            cyc_reg     <= '0;
            run_reg     <= '0;
            in_band     <= 1'b0;
            settle_time <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                target_reg  <= v_target;
                tol_reg     <= tol;
                cyc_reg     <= '0;
                run_reg     <= '0;
                in_band     <= 1'b0;
                settle_time <= '0;
            end else if (state_reg == ST_TRACK) begin
                cyc_reg <= cyc_next;
                run_reg <= run_next;
                in_band <= in_now;
                if (settle_hit) begin
                    settle_time <= cyc_next - HOLD_C + 1'b1;
                    done        <= 1'b1;
                end else if (timeout_hit) begin
                    done <= 1'b1;
                end
            end
        end
    end

`ifdef RC_SETTLE_PEAK_EN
    logic           seen_band_reg;
    logic [WIDTH:0] peak_reg;

    // Peak tracking is armed by the first in-band sample, which is itself included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seen_band_reg <= 1'b0;
            peak_reg      <= '0;
        end else if (start) begin
            seen_band_reg <= 1'b0;
            peak_reg      <= '0;
        end else if (state_reg == ST_TRACK) begin
            if (in_now) begin
                seen_band_reg <= 1'b1;
            end
            if ((seen_band_reg || in_now) && (err > peak_reg)) begin
                peak_reg <= err;
            end
        end
    end

    assign peak_err = peak_reg;
`else
    assign peak_err = '0;
`endif

    assign busy      = (state_reg == ST_TRACK);
    assign settled   = (state_reg == ST_SETTLED);
    assign timed_out = (state_reg == ST_TIMEOUT);

endmodule

// File: tb/tb_rc_settle_monitor.sv
// Testbench for rc_settle_monitor. It uses default parameters
// (HOLD_CYCLES=8, MAX_CYCLES=1000). The bench combines table-driven vectors,
// hand-written corner-case sequences, and randomized runs. The randomized
// runs are checked against a window-scan reference model.
module tb_rc_settle_monitor;

    localparam int W    = 16;
    localparam int HOLD = 8;
    localparam int MAXC = 1000;
    localparam int NS   = MAXC + 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  v_target = '0;
    logic [W-1:0]  tol = '0;
    logic [W-1:0]  v_meas = '0;
    logic          busy, done, settled, timed_out, in_band;
    logic [15:0]   settle_time;
    logic [W:0]    peak_err;

    int n_cmp = 0;
    int n_bad = 0;
    int samp [1:NS];

    rc_settle_monitor dut (
        .clk(clk), .rst(rst), .start(start), .v_target(v_target), .tol(tol),
        .v_meas(v_meas), .busy(busy), .done(done), .settled(settled),
        .timed_out(timed_out), .in_band(in_band), .settle_time(settle_time),
        .peak_err(peak_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    tg;
        int    tl;
        int    na;
        int    va;
        int    vb;
        bit    alt;
        int    exp_st;
        int    exp_dec;
        bit    exp_to;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit inb(input int tg, input int tl, input int k);
        int e;
        e = samp[k] - tg;
        if (e < 0) e = -e;
        return e <= tl;
    endfunction

    // Reference model: the first window of HOLD in-band samples that ends
    // by MAXC decides the result. If there is no such window, the run times
    // out at sample MAXC.
    task automatic model(input int tg, input int tl, output int st, output int dec, output bit to);
        st = 0; dec = MAXC; to = 1'b1;
        for (int i = 1; i <= MAXC - HOLD + 1; i++) begin
            bit all_in;
            all_in = 1'b1;
            for (int j = i; j < i + HOLD; j++) all_in &= inb(tg, tl, j);
            if (all_in) begin
                st = i; dec = i + HOLD - 1; to = 1'b0;
                break;
            end
        end
    endtask

    function automatic int exp_peak(input int tg, input int tl, input int dec);
        int p, e;
        bit seen;
        p = 0; seen = 1'b0;
        for (int k = 1; k <= dec; k++) begin
            if (inb(tg, tl, k)) seen = 1'b1;
            e = samp[k] - tg;
            if (e < 0) e = -e;
            if (seen && e > p) p = e;
        end
`ifdef RC_SETTLE_PEAK_EN
        return p;
`else
        return 0;
`endif
    endfunction

    // Issue start, then feed samp[] one sample per cycle until done or the bound.
    task automatic measure(input int tg, input int tl, output int done_at);
        @(negedge clk);
        start = 1'b1; v_target = W'(tg); tol = W'(tl);
        @(negedge clk);
        start = 1'b0;
        done_at = 0;
        for (int k = 1; k <= MAXC + 2 && done_at == 0; k++) begin
            v_meas = W'(samp[k]);
            @(negedge clk);
            if (done) done_at = k;
        end
    endtask

    task automatic check_result(input string name, input int tg, input int tl, input int done_at,
                                input int est, input int edec, input bit eto);
        chk({name, ".done_at"}, done_at, edec);
        chk({name, ".settle_time"}, settle_time, est);
        chk({name, ".settled"}, settled, !eto);
        chk({name, ".timed_out"}, timed_out, eto);
        chk({name, ".in_band"}, in_band, inb(tg, tl, edec));
        chk({name, ".peak_err"}, peak_err, exp_peak(tg, tl, edec));
        @(negedge clk);
        chk({name, ".done_pulse"}, done, 0);
        chk({name, ".busy"}, busy, 0);
        $display("run %-10s target=%0d tol=%0d done_at=%0d settle_time=%0d timed_out=%0d",
                 name, tg, tl, done_at, settle_time, timed_out);
    endtask

    function automatic void fill(input vec_t v);
        for (int k = 1; k <= NS; k++) begin
            if (v.alt) samp[k] = (k % 2 == 1) ? v.va : v.vb;
            else       samp[k] = (k <= v.na) ? v.va : v.vb;
        end
    endfunction

    initial begin
        vec_t vecs [7];
        int done_at, est, edec, saw_done;
        bit eto;

        vecs[0] = '{"clean",    1000, 10,     4,   0,     1005,   1'b0, 5,   12,   1'b0};
        vecs[1] = '{"alt_edge", 1000, 10,     0,   990,   1010,   1'b1, 1,   8,    1'b0};
        vecs[2] = '{"extreme",  -32768, 65534, 3,  32767, -32760, 1'b0, 4,   11,   1'b0};
        vecs[3] = '{"ext_eq",   -32768, 65535, 0,  0,     32767,  1'b0, 1,   8,    1'b0};
        vecs[4] = '{"tol0",     5,    0,      0,   0,     5,      1'b0, 1,   8,    1'b0};
        vecs[5] = '{"timeout",  1000, 10,     NS,  0,     0,      1'b0, 0,   1000, 1'b1};
        vecs[6] = '{"tie",      1000, 10,     992, 0,     1000,   1'b0, 993, 1000, 1'b0};

        // Reset state.
        #3;
        chk("rst.busy", busy, 0); chk("rst.done", done, 0); chk("rst.settled", settled, 0);
        chk("rst.timed_out", timed_out, 0); chk("rst.settle_time", settle_time, 0);
        @(negedge clk); rst = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 7; i++) begin
            fill(vecs[i]);
            measure(vecs[i].tg, vecs[i].tl, done_at);
            check_result(vecs[i].name, vecs[i].tg, vecs[i].tl, done_at,
                         vecs[i].exp_st, vecs[i].exp_dec, vecs[i].exp_to);
        end

        // Ringing: 0,0, in band on samples 3-6, 1011 on 7-8, then in band.
        for (int k = 1; k <= NS; k++)
            samp[k] = (k <= 2) ? 0 : (k <= 6) ? 1005 : (k <= 8) ? 1011 : 1000;
        measure(1000, 10, done_at);
`ifdef RC_SETTLE_PEAK_EN
        chk("ring.peak_const", peak_err, 11);
`else
        chk("ring.peak_const", peak_err, 0);
`endif
        check_result("ring", 1000, 10, done_at, 9, 16, 1'b0);

        // After settling, v_meas is ignored and all outputs hold.
        v_meas = 16'h8000;
        repeat (3) @(negedge clk);
        chk("hold.settled", settled, 1); chk("hold.settle_time", settle_time, 9);
        chk("hold.in_band", in_band, 1); chk("hold.done", done, 0);

        // Extreme error on the first sample: err=65535 against tol=65534.
        @(negedge clk); start = 1'b1; v_target = 16'h8000; tol = 16'hFFFE;
        @(negedge clk); start = 1'b0; v_meas = 16'h7FFF;
        chk("ext1.busy", busy, 1);
        @(negedge clk);
        chk("ext1.in_band", in_band, 0);

        // Restart mid-run: first run toward 1000, then a restart toward 500.
        for (int k = 1; k <= NS; k++) samp[k] = 500;
        @(negedge clk); start = 1'b1; v_target = 16'd1000; tol = 16'd10;
        @(negedge clk); start = 1'b0; v_meas = 16'd1005;
        saw_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        start = 1'b1; v_target = 16'd500; tol = 16'd10;
        @(negedge clk); start = 1'b0;
        if (done) saw_done = 1;
        chk("restart.no_done", saw_done, 0);
        chk("restart.settle_time_clr", settle_time, 0);
        done_at = 0;
        for (int k = 1; k <= MAXC + 2 && done_at == 0; k++) begin
            v_meas = W'(samp[k]);
            @(negedge clk);
            if (done) done_at = k;
        end
        check_result("restart", 500, 10, done_at, 1, 8, 1'b0);

        // Reset asserted mid-run.
        @(negedge clk); start = 1'b1; v_target = 16'd1000; tol = 16'd10;
        @(negedge clk); start = 1'b0; v_meas = 16'd1005;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mrst.busy", busy, 0); chk("mrst.done", done, 0); chk("mrst.settled", settled, 0);
        chk("mrst.in_band", in_band, 0); chk("mrst.settle_time", settle_time, 0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; rst = 1'b1;
        saw_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        chk("mrst.quiet", saw_done, 0);

        // Randomized runs checked against the reference model.
        for (int r = 0; r < 25; r++) begin
            int tg, tl, pre, dev;
            tg  = int'($urandom_range(40000)) - 20000;
            tl  = int'($urandom_range(50));
            pre = int'($urandom_range(30));
            for (int k = 1; k <= NS; k++) begin
                if (k <= pre) samp[k] = tg + 500;
                else begin
                    dev = int'($urandom_range(tl + 2));
                    samp[k] = ($urandom_range(1) == 1) ? tg + dev : tg - dev;
                end
            end
            model(tg, tl, est, edec, eto);
            measure(tg, tl, done_at);
            check_result($sformatf("rand%0d", r), tg, tl, done_at, est, edec, eto);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rc_settle_monitor.md
Name: rc_settle_monitor

Overview:
- Downstream consumer of the RC model output (v_out).
- On a start request it latches a target value and a tolerance, then samples the model output every cycle.
- Reports the sample index at which the output entered and stayed within tolerance for HOLD_CYCLES consecutive samples (settling time), or flags a timeout.
- Serves as the self-checking step-response stage in model test harnesses.

Parameters:
WIDTH, 16, bit width of signed two's-complement fixed-point v_meas/v_target/tol (all three share one format; the caller aligns formats)
HOLD_CYCLES, 8, consecutive in-band samples required to declare settled; legal range 1..MAX_CYCLES
MAX_CYCLES, 1000, maximum samples before timeout; must be < 2**CNT_W
CNT_W, 16, width of the sample counters and settle_time

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0); deassertion is synchronous to clk
start  input  1  one-cycle request; latches v_target and tol, begins a measurement
v_target  input  WIDTH  signed target value, sampled only when start=1
tol  input  WIDTH  unsigned tolerance magnitude, sampled only when start=1
v_meas  input  WIDTH  signed model output (rc_model v_out), sampled every TRACK cycle
busy  output  1  high while in TRACK
done  output  1  one-cycle pulse on entering SETTLED or TIMEOUT
settled  output  1  level, high in SETTLED
timed_out  output  1  level, high in TIMEOUT
in_band  output  1  registered result of the most recent sample's tolerance test
settle_time  output  CNT_W  index (1-based) of the first sample of the qualifying in-band run; 0 otherwise
peak_err  output  WIDTH+1  see Optional Feature

Behaviour:
- States: IDLE, TRACK, SETTLED, TIMEOUT. Reset: state=IDLE; all outputs, counters, and latched target/tol = 0.
- start=1 in any state (including TRACK): latch v_target and tol, clear cyc/run/settle_time/in_band/peak_err, clear settled/timed_out, next state TRACK. No done pulse for the aborted run.
- TRACK, per cycle:
  - cyc increments; the first TRACK cycle is sample 1.
  - err = |v_meas - target| computed in WIDTH+1 bits, so there is no overflow at extremes.
  - in_band = (err <= tol); the equality case counts as in band.
  - run = in_band ? run+1 : 0.
- Settle: when run reaches HOLD_CYCLES on sample cyc:
  - settle_time <= cyc - HOLD_CYCLES + 1.
  - state -> SETTLED; done pulses for 1 cycle; settled stays high until the next start or reset.
- Timeout: when sample cyc == MAX_CYCLES and settle did not occur on that sample:
  - state -> TIMEOUT; done pulses; timed_out stays high; settle_time stays 0.
  - If settle and timeout occur on the same sample, settle wins.
- SETTLED/TIMEOUT: hold all outputs; v_meas is ignored; only start or reset exits.
- Latency: start on edge t -> busy=1 after t; sample 1 is evaluated at edge t+1. done and settled/timed_out are registered and appear one cycle after the deciding sample's edge.
- Reset asserted mid-TRACK: immediate return to IDLE with all outputs 0; no done pulse.
- start while rst is asserted is ignored.

Optional Feature:
- Macro RC_SETTLE_PEAK_EN.
- Defined: peak_err tracks the maximum err over all TRACK samples that follow the first in-band sample (overshoot/ringing magnitude). It is cleared on start and frozen in SETTLED/TIMEOUT.
- Undefined: the peak_err port still exists and is tied to 0; no tracking logic is synthesized.

Test Plan:
- Reset mid-run: HOLD=8, target=1000, tol=10; start, drive v_meas=1005 for 3 cycles, pull rst=0 -> busy/done/settled/in_band/settle_time all 0 immediately, state IDLE; release rst, no spurious done.
- Clean step: target=1000, tol=10, v_meas=0 for samples 1-4, then 1005 constant -> done pulses after sample 12, settled=1, settle_time=5.
- Ringing: in band on samples 3-6, v_meas=1011 on samples 7-8, in band from sample 9 -> settle_time=9, done after sample 16; with RC_SETTLE_PEAK_EN, peak_err=11.
- Boundary and extremes:
  - tol=10, v_meas alternating 990/1010 -> every sample is in band; settles with settle_time=1.
  - target=-32768, v_meas=32767 -> err=65535, in_band=0, no wrap.
- Timeout: MAX_CYCLES=1000, v_meas never in band -> done pulses after sample 1000, timed_out=1, settle_time=0.
- Timeout tie: HOLD=8, in band from sample 993 -> settle on sample 1000 wins, settle_time=993, timed_out=0.
- Restart: a second start during sample 6 with target=500 -> counters cleared, no done for the first run; the next sample is numbered 1 against target 500.
